// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit computer: fetch FSM states and fetch constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    ISSUE_OP  = 3'd0,
    CAPT_OP   = 3'd1,
    ISSUE_IMM = 3'd2,
    CAPT_IMM  = 3'd3,
    HOLD      = 3'd4
  } fetch_state_t;

  // Opcode bit marking a 2-byte instruction (only meaningful with FETCH_IMM_EN).
  localparam int unsigned IMM_FLAG_BIT = 7;
  localparam logic [7:0]  RESET_PC     = 8'h00;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-port and decoder-handshake signals of the fetch stage.
// master: the fetch unit; slave: memory / execute / decoder side.
interface fetch_unit_if;

  logic [7:0] mem_addr;
  logic       mem_get;
  logic [7:0] mem_out;
  logic       bus_busy;
  logic       halt;
  logic       jump;
  logic [7:0] jump_addr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [7:0] instr_pc;

  modport master (
    output mem_addr, mem_get, instr_valid, opcode, operand, instr_pc,
    input  mem_out, bus_busy, halt, jump, jump_addr, instr_ready
  );

  modport slave (
    input  mem_addr, mem_get, instr_valid, opcode, operand, instr_pc,
    output mem_out, bus_busy, halt, jump, jump_addr, instr_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads opcode (and optional immediate)
// bytes from memory and holds the assembled instruction for the decoder.
// Optional feature macro: FETCH_IMM_EN enables 2-byte instructions (opcode[7]).
module fetch_unit
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  fetch_state_t r_state;
  logic [7:0]   r_pc;
  logic [7:0]   r_instr_pc;
  logic [7:0]   r_opcode;
  logic         r_valid;
  logic         w_issue;
  logic         w_mem_get;

`ifdef FETCH_IMM_EN
  logic [7:0]   r_operand;
`endif

  // Memory read request: only in issue states, never during reset or a redirect.
  always_comb begin
    w_issue = 1'b0;
    case (r_state)
      ISSUE_OP:  w_issue = !bus.bus_busy && !bus.halt;
`ifdef FETCH_IMM_EN
      ISSUE_IMM: w_issue = !bus.bus_busy;  // halt never strands a started instruction
`endif
      default:   w_issue = 1'b0;
    endcase
    w_mem_get = w_issue && rst_n && !bus.jump;
  end

  // FSM, PC and instruction registers; jump overrides everything but reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ISSUE_OP;
      r_pc       <= RESET_PC;
      r_instr_pc <= 8'h00;
      r_opcode   <= 8'h00;
      r_valid    <= 1'b0;
`ifdef FETCH_IMM_EN
      r_operand  <= 8'h00;
`endif
    end else if (bus.jump) begin
      // Drops any in-flight byte and any same-cycle handshake.
      r_pc    <= bus.jump_addr;
      r_valid <= 1'b0;
      r_state <= ISSUE_OP;
    end else begin
      case (r_state)
        ISSUE_OP: begin
          if (w_mem_get) begin
            r_instr_pc <= r_pc;
            r_pc       <= r_pc + 8'd1;
            r_state    <= CAPT_OP;
          end
        end
        CAPT_OP: begin
          r_opcode <= bus.mem_out;
`ifdef FETCH_IMM_EN
          if (bus.mem_out[IMM_FLAG_BIT]) begin
            r_state <= ISSUE_IMM;
          end else begin
            r_operand <= 8'h00;
            r_valid   <= 1'b1;
            r_state   <= HOLD;
          end
`else
          r_valid <= 1'b1;
          r_state <= HOLD;
`endif
        end
`ifdef FETCH_IMM_EN
        ISSUE_IMM: begin
          if (w_mem_get) begin
            r_pc    <= r_pc + 8'd1;
            r_state <= CAPT_IMM;
          end
        end
        CAPT_IMM: begin
          r_operand <= bus.mem_out;
          r_valid   <= 1'b1;
          r_state   <= HOLD;
        end
`endif
        HOLD: begin
          if (bus.instr_ready) begin
            r_valid <= 1'b0;
            r_state <= ISSUE_OP;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ISSUE_OP;
        end
      endcase
    end
  end

  assign bus.mem_addr    = r_pc;
  assign bus.mem_get     = w_mem_get;
  assign bus.instr_valid = r_valid;
  assign bus.opcode      = r_opcode;
  assign bus.instr_pc    = r_instr_pc;
`ifdef FETCH_IMM_EN
  assign bus.operand     = r_operand;
`else
  assign bus.operand     = 8'h00;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Works with or without FETCH_IMM_EN.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: byte appears on mem_out the cycle after a get edge.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_get) bus.mem_out <= mem[bus.mem_addr];
  end

  int n_checks = 0;
  int n_err    = 0;
  int m_pc;  // reference program counter

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction length in bytes as seen by the fetch stage.
  function automatic int ilen(input logic [7:0] op);
`ifdef FETCH_IMM_EN
    return op[7] ? 2 : 1;
`else
    return 1;
`endif
  endfunction

  // Fetch one instruction starting in ISSUE_OP and retire it through the handshake.
  task automatic fetch_one(input int busy, input int stall, input bit halt_mid);
    logic [7:0] e_pc, e_op, e_imm;
    int len, k;
    e_pc  = m_pc[7:0];
    e_op  = mem[e_pc];
    len   = ilen(e_op);
    e_imm = (len == 2) ? mem[e_pc + 8'd1] : 8'h00;
    bus.instr_ready = (stall == 0);
    for (int i = 0; i < busy; i++) begin
      bus.bus_busy = 1'b1;
      #1;
      chk("busy_no_get", bus.mem_get, 1'b0);
      step();
    end
    bus.bus_busy = 1'b0;
    #1;
    chk("issue_get", bus.mem_get, 1'b1);
    chk("issue_addr", bus.mem_addr, e_pc);
    step();
    k = 1;
    if (halt_mid) bus.halt = 1'b1;
    while (!bus.instr_valid && k < 12) begin
      step();
      k++;
    end
    chk("latency", k, 2 * len);
    chk("opcode", bus.opcode, e_op);
    chk("operand", bus.operand, e_imm);
    chk("instr_pc", bus.instr_pc, e_pc);
    for (int s = 0; s < stall; s++) begin
      chk("hold_no_get", bus.mem_get, 1'b0);
      step();
      chk("hold_valid", bus.instr_valid, 1'b1);
      chk("hold_opcode", bus.opcode, e_op);
      chk("hold_operand", bus.operand, e_imm);
      chk("hold_instr_pc", bus.instr_pc, e_pc);
    end
    bus.halt        = 1'b0;
    bus.instr_ready = 1'b1;
    step();
    chk("after_accept_valid", bus.instr_valid, 1'b0);
    m_pc = (m_pc + len) % 256;
  endtask

  // Start a fetch in ISSUE_OP, then redirect 'offset' cycles after the issue.
  task automatic jump_mid(input int offset, input logic [7:0] tgt);
    int len;
    len = ilen(mem[m_pc[7:0]]);
    bus.instr_ready = 1'b1;
    #1;
    chk("jm_issue_get", bus.mem_get, 1'b1);
    for (int i = 0; i < offset; i++) step();
    if (offset >= 2 * len) chk("jm_hold_valid", bus.instr_valid, 1'b1);
    bus.jump      = 1'b1;
    bus.jump_addr = tgt;
    #1;
    chk("jm_no_get", bus.mem_get, 1'b0);
    step();
    bus.jump = 1'b0;
    #1;
    chk("jm_valid", bus.instr_valid, 1'b0);
    chk("jm_get", bus.mem_get, 1'b1);
    chk("jm_addr", bus.mem_addr, tgt);
    m_pc = tgt;
  endtask

  initial begin
    int off, len;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h05;
    mem[1] = 8'h11;
    mem[2] = 8'h22;
    mem[3] = 8'h82;
    mem[4] = 8'h7A;
    mem[5] = 8'h33;

    // Reset
    rst_n           = 1'b0;
    bus.bus_busy    = 1'b0;
    bus.halt        = 1'b0;
    bus.jump        = 1'b0;
    bus.jump_addr   = 8'h00;
    bus.instr_ready = 1'b1;
    step();
    step();
    chk("rst_get", bus.mem_get, 1'b0);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_opcode", bus.opcode, 8'h00);
    chk("rst_operand", bus.operand, 8'h00);
    chk("rst_instr_pc", bus.instr_pc, 8'h00);
    chk("rst_addr", bus.mem_addr, 8'h00);
    rst_n = 1'b1;
    m_pc  = 0;

    // Sequential program from address 0, including the 2-byte op at 3.
    for (int i = 0; i < 5; i++) fetch_one(0, 0, 1'b0);

    // halt blocks a new fetch
    bus.halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_no_get", bus.mem_get, 1'b0);
      chk("halt_no_valid", bus.instr_valid, 1'b0);
      step();
    end
    bus.halt = 1'b0;

    fetch_one(3, 0, 1'b0);  // bus_busy during ISSUE_OP
    fetch_one(0, 5, 1'b0);  // decoder stalls 5 cycles
    mem[m_pc[7:0]] = mem[m_pc[7:0]] | 8'h80;
    fetch_one(0, 0, 1'b1);  // halt raised after the instruction started

    // PC wrap: opcode at FF, immediate (if any) at 00.
    mem[8'hFF] = 8'h80 | 8'($urandom);
    jump_mid(1, 8'hFF);
    fetch_one(0, 0, 1'b0);
    fetch_one(0, 0, 1'b0);

    // Redirect while the last byte of an instruction is in flight.
    mem[m_pc[7:0]] = mem[m_pc[7:0]] | 8'h80;
`ifdef FETCH_IMM_EN
    jump_mid(3, 8'h40);
`else
    jump_mid(1, 8'h40);
`endif
    fetch_one(0, 0, 1'b0);

    // Redirect in HOLD together with instr_ready.
    jump_mid(2 * ilen(mem[m_pc[7:0]]), 8'h90);
    fetch_one(0, 0, 1'b0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        len = ilen(mem[m_pc[7:0]]);
        off = $urandom_range(1, 2 * len);
        jump_mid(off, 8'($urandom));
      end
      fetch_one($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
